// File: rtl/mccb_pkg.sv
// Shared types and helpers for the multi-channel counter bank.
// Provides the digit type, radix limits and a single-digit step function
// that returns the next digit value plus a carry (up) or borrow (down) flag.
package mccb_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t DEC_MAX = 4'd9;
  localparam digit_t HEX_MAX = 4'hF;

  // Result of stepping one digit: new value and carry/borrow out.
  typedef struct packed {
    digit_t digit;
    logic   carry;
  } digit_step_t;

  // Step one digit up or down in decimal or hex; carry is set when it rolls.
  function automatic digit_step_t next_digit(input digit_t d, input logic is_dec,
                                             input logic up);
    digit_t      max_v;
    digit_step_t r;
    max_v   = is_dec ? DEC_MAX : HEX_MAX;
    r.digit = d;
    r.carry = 1'b0;
    if (up) begin
      if (d == max_v) begin
        r.digit = '0;
        r.carry = 1'b1;
      end else begin
        r.digit = d + DIGIT_W'(1);
      end
    end else begin
      if (d == '0) begin
        r.digit = max_v;
        r.carry = 1'b1;
      end else begin
        r.digit = d - DIGIT_W'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_channel_counter_bank_radix_counter.sv
// One counter channel: NUM_DIGITS digits, decimal or hex, wrap or saturate.
// Ports: clk, reset (async, active-high), inc/dec/clr one-cycle pulses,
//        digits (digit 0 = LSD), ovf sticky boundary flag.
// Optional macro OVF_STICKY_EN: when undefined ovf is tied low.
module radix_counter
  import mccb_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter bit          IS_DEC     = 1'b0,
  parameter bit          WRAP       = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                inc,
  input  logic                                dec,
  input  logic                                clr,
  output logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits,
  output logic                                ovf
);

  logic                               up_c;
  logic                               dn_c;
  logic                               move_c;
  logic                               boundary_c;
  logic [NUM_DIGITS:0]                carry_c;
  digit_step_t                        step_c [NUM_DIGITS];
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] ripple_c;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] cnt_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] cnt_d;

  // inc and dec together cancel out
  assign up_c   = inc & ~dec;
  assign dn_c   = dec & ~inc;
  assign move_c = up_c | dn_c;

  // Ripple carry/borrow LSD to MSD; a carry out of the MSD means the whole
  // counter sat at max (up) or zero (down), i.e. a boundary event.
  always_comb begin
    carry_c    = '0;
    carry_c[0] = 1'b1;
    ripple_c   = cnt_q;
    step_c     = '{default: '0};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      step_c[i] = next_digit(cnt_q[i], IS_DEC, up_c);
      if (carry_c[i]) ripple_c[i] = step_c[i].digit;
      carry_c[i+1] = carry_c[i] & step_c[i].carry;
    end
  end

  // clr suppresses the boundary event
  assign boundary_c = ~clr & move_c & carry_c[NUM_DIGITS];

  // Next count: clear, else step unless saturating at a boundary
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (move_c && !(boundary_c && !WRAP)) begin
      cnt_d = ripple_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign digits = cnt_q;

`ifdef OVF_STICKY_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky flag: set by a boundary event, cleared only by clr
  always_comb begin
    ovf_d = ovf_q;
    if (clr)             ovf_d = 1'b0;
    else if (boundary_c) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_counter_bank.sv
// Bank of NUM_CH up/down counters with a timed rotator that shows one
// channel at a time on a shared registered display output.
// Ports: clk, reset (async, active-high), inc/dec/clr per channel, hold
//        (freeze rotation); encoded/digit_point/ovf per channel; disp_sel,
//        disp_encoded, disp_digit_point for the shared output.
// Optional macro OVF_STICKY_EN enables the sticky ovf flags.
module multi_channel_counter_bank
  import mccb_pkg::*;
#(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       NUM_DIGITS = 4,
  parameter logic [NUM_CH-1:0] DEC_MASK   = NUM_CH'(4'b0101),
  parameter bit                WRAP       = 1'b1,
  parameter int unsigned       DWELL_CYC  = 200_000_000,
  localparam int unsigned      SEL_W      = $clog2(NUM_CH)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_CH-1:0]                             inc,
  input  logic [NUM_CH-1:0]                             dec,
  input  logic [NUM_CH-1:0]                             clr,
  input  logic                                          hold,
  output logic [NUM_CH-1:0][NUM_DIGITS-1:0][DIGIT_W-1:0] encoded,
  output logic [NUM_CH-1:0][NUM_DIGITS-1:0]             digit_point,
  output logic [NUM_CH-1:0]                             ovf,
  output logic [SEL_W-1:0]                              disp_sel,
  output logic [NUM_DIGITS-1:0][DIGIT_W-1:0]            disp_encoded,
  output logic [NUM_DIGITS-1:0]                         disp_digit_point
);

  localparam int unsigned         DW_W     = $clog2(DWELL_CYC);
  localparam logic [NUM_DIGITS-1:0] DP_RST = NUM_DIGITS'(DEC_MASK[0]);

  logic [DW_W-1:0]                    dwell_q, dwell_d;
  logic [SEL_W-1:0]                   sel_q, sel_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] disp_enc_q, disp_enc_d;
  logic [NUM_DIGITS-1:0]              disp_dp_q, disp_dp_d;

  // One counter per channel; decimal point marks decimal channels
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    radix_counter #(
      .NUM_DIGITS (NUM_DIGITS),
      .IS_DEC     (DEC_MASK[c]),
      .WRAP       (WRAP)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (inc[c]),
      .dec    (dec[c]),
      .clr    (clr[c]),
      .digits (encoded[c]),
      .ovf    (ovf[c])
    );
    assign digit_point[c] = NUM_DIGITS'(DEC_MASK[c]);
  end

  // Rotator and shared-output capture
  always_comb begin
    dwell_d    = dwell_q;
    sel_d      = sel_q;
    disp_enc_d = encoded[sel_q];
    disp_dp_d  = digit_point[sel_q];
    if (!hold) begin
      if (dwell_q == DW_W'(DWELL_CYC - 1)) begin
        dwell_d = '0;
        sel_d   = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q    <= '0;
      sel_q      <= '0;
      disp_enc_q <= '0;
      disp_dp_q  <= DP_RST;
    end else begin
      dwell_q    <= dwell_d;
      sel_q      <= sel_d;
      disp_enc_q <= disp_enc_d;
      disp_dp_q  <= disp_dp_d;
    end
  end

  assign disp_sel         = sel_q;
  assign disp_encoded     = disp_enc_q;
  assign disp_digit_point = disp_dp_q;

endmodule

// File: tb/tb_multi_channel_counter_bank.sv
// Directed bench for multi_channel_counter_bank: table of per-cycle vectors
// plus hand-written sequences for preload, rotation, hold and mid-run reset.
module tb_multi_channel_counter_bank;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            inc, dec, clr;
  logic                  hold;
  logic [3:0][3:0][3:0]  encoded;
  logic [3:0][3:0]       digit_point;
  logic [3:0]            ovf;
  logic [1:0]            disp_sel;
  logic [3:0][3:0]       disp_encoded;
  logic [3:0]            disp_digit_point;

  int total = 0;
  int bad   = 0;

  // ch1 and ch2 decimal, ch0 and ch3 hex
  multi_channel_counter_bank #(
    .NUM_CH     (4),
    .NUM_DIGITS (4),
    .DEC_MASK   (4'b0110),
    .WRAP       (1'b1),
    .DWELL_CYC  (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .inc              (inc),
    .dec              (dec),
    .clr              (clr),
    .hold             (hold),
    .encoded          (encoded),
    .digit_point      (digit_point),
    .ovf              (ovf),
    .disp_sel         (disp_sel),
    .disp_encoded     (disp_encoded),
    .disp_digit_point (disp_digit_point)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  inc;
    logic [3:0]  dec;
    logic [3:0]  clr;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] e3;
    logic [3:0]  ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] i, input logic [3:0] d, input logic [3:0] c,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3,
                              input logic [3:0] ov);
    vec_t v;
    v.inc = i; v.dec = d; v.clr = c;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.ov = ov;
    return v;
  endfunction

  function automatic logic [3:0] ovf_exp(input logic [3:0] ov);
`ifdef OVF_STICKY_EN
    return ov;
`else
    return ov & 4'b0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " encoded"}, 64'(encoded), 64'h0);
    chk({tag, " ovf"}, 64'(ovf), 64'h0);
    chk({tag, " disp_sel"}, 64'(disp_sel), 64'h0);
    chk({tag, " disp_encoded"}, 64'(disp_encoded), 64'h0);
    chk({tag, " disp_dp"}, 64'(disp_digit_point), 64'h0);
  endtask

  initial begin
    int         prev_sel;
    int         exp_sel;
    logic [3:0] exp_dp;

    reset = 1'b1; inc = '0; dec = '0; clr = '0; hold = 1'b0;
    tick(); tick();
    chk_reset_state("reset");
    chk("digit_point", 64'(digit_point), 64'h0000_0000_0000_0110);
    reset = 1'b0;

    // rows: inc, dec, clr, ch0, ch1, ch2, ch3, ovf after the edge
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0002, 16'h0002, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0004, 16'h0004, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0006, 16'h0006, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0007, 16'h0007, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0008, 16'h0008, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h0009, 16'h0009, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h000A, 16'h0010, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h000B, 16'h0011, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0011, 4'b0000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0001, 4'b0001, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b1100, 4'b0000, 16'h000C, 16'h0012, 16'h9999, 16'hFFFF, 4'b1100));
    vecs.push_back(mk(4'b1100, 4'b0000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0000, 4'b1100));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0001, 4'b1100));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0002, 4'b1100));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0003, 4'b1100));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0004, 4'b1100));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0005, 4'b1100));
    vecs.push_back(mk(4'b1000, 4'b1000, 4'b0000, 16'h000C, 16'h0012, 16'h0000, 16'h0005, 4'b1100));
    vecs.push_back(mk(4'b1000, 4'b0000, 4'b1000, 16'h000C, 16'h0012, 16'h0000, 16'h0000, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'b0100, 4'b0100, 16'h000C, 16'h0012, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0011, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000));
    vecs.push_back(mk(4'b0000, 4'b0001, 4'b0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0001));
    vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0001));
    vecs.push_back(mk(4'b0000, 4'b0000, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000));

    foreach (vecs[n]) begin
      inc = vecs[n].inc; dec = vecs[n].dec; clr = vecs[n].clr;
      tick();
      chk($sformatf("vec%0d encoded", n), 64'(encoded),
          64'({vecs[n].e3, vecs[n].e2, vecs[n].e1, vecs[n].e0}));
      chk($sformatf("vec%0d ovf", n), 64'(ovf), 64'(ovf_exp(vecs[n].ov)));
    end
    inc = '0; dec = '0; clr = '0;

    // Preload ch1 (decimal) to 9999, then one more inc wraps
    inc = 4'b0010;
    repeat (9999) tick();
    inc = '0;
    chk("preload ch1", 64'(encoded[1]), 64'h9999);
    chk("preload ovf", 64'(ovf), 64'h0);
    inc = 4'b0010;
    tick();
    inc = '0;
    chk("wrap ch1", 64'(encoded[1]), 64'h0000);
    chk("wrap ovf", 64'(ovf), 64'(ovf_exp(4'b0010)));
    clr = 4'b0010;
    tick();
    clr = '0;
    chk("clr ovf", 64'(ovf), 64'h0);

    // Rotation: load distinct values with rotation frozen, then release
    hold = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inc = 4'b1111; tick();
    inc = 4'b1110; tick();
    inc = 4'b1100; tick();
    inc = 4'b1000; tick();
    inc = '0;
    chk("rot load", 64'(encoded), 64'h0004_0003_0002_0001);
    chk("rot held sel", 64'(disp_sel), 64'h0);
    hold = 1'b0;
    prev_sel = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_sel = (k / 4) % 4;
      exp_dp  = (prev_sel == 1 || prev_sel == 2) ? 4'b0001 : 4'b0000;
      chk($sformatf("rot%0d sel", k), 64'(disp_sel), 64'(exp_sel));
      chk($sformatf("rot%0d disp", k), 64'(disp_encoded), 64'(prev_sel + 1));
      chk($sformatf("rot%0d dp", k), 64'(disp_digit_point), 64'(exp_dp));
      prev_sel = exp_sel;
    end

    // Hold freezes selection and dwell count
    hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("hold%0d sel", k), 64'(disp_sel), 64'h1);
    end
    hold = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("resume%0d sel", k), 64'(disp_sel), 64'h1);
    end
    tick();
    chk("resume adv sel", 64'(disp_sel), 64'h2);
    chk("resume disp", 64'(disp_encoded), 64'h0002);

    // Reset mid-run with ch0 = 7 and disp_sel = 2
    hold = 1'b1;
    clr = 4'b0001; tick();
    clr = '0;
    inc = 4'b0001;
    repeat (7) tick();
    inc = '0;
    chk("pre-reset ch0", 64'(encoded[0]), 64'h0007);
    chk("pre-reset sel", 64'(disp_sel), 64'h2);
    #3 reset = 1'b1;
    #1;
    chk_reset_state("async reset");
    tick(); tick();
    chk_reset_state("held reset");
    reset = 1'b0;
    inc = 4'b0001;
    tick();
    inc = '0;
    chk("post-reset ch0", 64'(encoded[0]), 64'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
